// File: rtl/prism_sp_rx_dispatch.sv
// prism_sp_rx_dispatch
// Frame-level scheduler between the GEM RX frame packer and the per-core RX
// meta/data FIFO pairs. On each start of frame one enabled core with room for
// the whole frame is picked round-robin. All data words and the closing meta
// descriptor of that frame are then steered to that core's FIFO pair. A frame
// that no core can take is dropped, and the drop is reported.
//
// Build option: define PRISM_SP_RX_DISPATCH_STATS_EN to build the per-core
// accepted-frame counters and the dropped-frame counter. When it is undefined,
// stat_frames and stat_drops are tied to 0.
//
// Ports
//   rx_clock, rx_resetn     : clock and synchronous active-low reset
//   in_sop, in_len          : frame start pulse and frame length in bytes
//   in_data_wr, in_data     : packed data word strobe and payload
//   in_meta_wr, in_meta     : end-of-frame meta descriptor strobe and payload
//   core_en, data_wr_count, meta_full : per-core status, sampled at in_sop
//   data_wr_en, data_wr_data: one-hot data FIFO write and broadcast data
//   meta_wr_en, meta_wr_data: one-hot meta FIFO write and broadcast meta
//   cur_core                : last granted core
//   drop                    : one-cycle pulse per dropped frame
//   stat_frames, stat_drops : statistics counters (optional)
//
// State  | meaning
// IDLE   | waiting for in_sop
// DECIDE | eligibility registered, round-robin grant this cycle
// STEER  | frame in flight, writes go to cur_core
// DROP   | frame discarded, waiting for its meta (or a new sop)

module prism_sp_rx_dispatch #(
  parameter int NRXCORES          = 4,
  parameter int DATA_WIDTH        = 64,
  parameter int META_WIDTH        = 32,
  parameter int RX_DATA_FIFO_SIZE = 4096,
  parameter int CNT_WIDTH         = 10
) (
  input  logic                                            rx_clock,
  input  logic                                            rx_resetn,
  input  logic                                            in_sop,
  input  logic [13:0]                                     in_len,
  input  logic                                            in_data_wr,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  input  logic                                            in_meta_wr,
  input  logic [META_WIDTH-1:0]                           in_meta,
  input  logic [NRXCORES-1:0]                             core_en,
  input  logic [NRXCORES*CNT_WIDTH-1:0]                   data_wr_count,
  input  logic [NRXCORES-1:0]                             meta_full,
  output logic [NRXCORES-1:0]                             data_wr_en,
  output logic [DATA_WIDTH-1:0]                           data_wr_data,
  output logic [NRXCORES-1:0]                             meta_wr_en,
  output logic [META_WIDTH-1:0]                           meta_wr_data,
  output logic [((NRXCORES > 1) ? $clog2(NRXCORES) : 1)-1:0] cur_core,
  output logic                                            drop,
  output logic [NRXCORES*32-1:0]                          stat_frames,
  output logic [31:0]                                     stat_drops
);

  localparam int          CORE_W     = (NRXCORES > 1) ? $clog2(NRXCORES) : 1;
  localparam int          NF_W       = $clog2(RX_DATA_FIFO_SIZE) + 1;
  localparam logic [31:0] BPW        = 32'(DATA_WIDTH / 8);
  localparam logic [31:0] FIFO_BYTES = 32'(RX_DATA_FIFO_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECIDE = 2'd1,
    S_STEER  = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NRXCORES-1:0] r_elig;
  logic [NRXCORES-1:0] w_elig;
  logic                w_sample_elig;
  logic [CORE_W-1:0]   r_rr_ptr;
  logic [CORE_W-1:0]   w_rr_ptr_nxt;
  logic [CORE_W-1:0]   r_cur_core;
  logic [CORE_W-1:0]   w_cur_core_nxt;
  logic                w_grant_vld;
  logic [CORE_W-1:0]   w_grant_idx;
  logic [CORE_W-1:0]   w_grant_ptr;
  logic [NRXCORES-1:0] r_data_wr_en;
  logic [NRXCORES-1:0] w_data_wr_en_nxt;
  logic [NRXCORES-1:0] r_meta_wr_en;
  logic [NRXCORES-1:0] w_meta_wr_en_nxt;
  logic [DATA_WIDTH-1:0] r_data_wr_data;
  logic [META_WIDTH-1:0] r_meta_wr_data;
  logic                r_drop;
  logic                w_drop_nxt;

  // Free space per core in bytes. The occupied byte count is formed at 32 bits
  // so an over-range word count saturates nfree at 0 instead of wrapping.
  always_comb begin
    logic [31:0]     used;
    logic [NF_W-1:0] nfree;
    w_elig = '0;
    used   = '0;
    nfree  = '0;
    for (int i = 0; i < NRXCORES; i++) begin
      used = 32'(data_wr_count[i*CNT_WIDTH +: CNT_WIDTH]) * BPW;
      if (used >= FIFO_BYTES) nfree = '0;
      else                    nfree = NF_W'(FIFO_BYTES - used);
      w_elig[i] = core_en[i] & ~meta_full[i] & (32'(nfree) >= 32'(in_len));
    end
  end

  // First eligible core at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j           = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_ptr = '0;
    for (int k = 0; k < NRXCORES; k++) begin
      j = (int'(r_rr_ptr) + k) % NRXCORES;
      if (!w_grant_vld && r_elig[CORE_W'(j)]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = CORE_W'(j);
        w_grant_ptr = CORE_W'((j + 1) % NRXCORES);
      end
    end
  end

  always_ff @(posedge rx_clock) begin
    if (!rx_resetn) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_cur_core_nxt   = r_cur_core;
    w_data_wr_en_nxt = '0;
    w_meta_wr_en_nxt = '0;
    w_drop_nxt       = 1'b0;
    w_sample_elig    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_sop) begin
          w_sample_elig = 1'b1;
          w_state_nxt   = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (in_sop) begin
          // Early restart: decide on the newer frame instead.
          w_sample_elig = 1'b1;
        end else if (w_grant_vld) begin
          w_cur_core_nxt = w_grant_idx;
          w_rr_ptr_nxt   = w_grant_ptr;
          w_state_nxt    = S_STEER;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_STEER: begin
        if (in_data_wr) w_data_wr_en_nxt[r_cur_core] = 1'b1;
        if (in_meta_wr) begin
          w_meta_wr_en_nxt[r_cur_core] = 1'b1;
          w_state_nxt                  = S_IDLE;
        end
        // A sop without a closing meta abandons the frame in flight.
        if (in_sop) begin
          w_sample_elig = 1'b1;
          w_state_nxt   = S_DECIDE;
          w_drop_nxt    = ~in_meta_wr;
        end
      end
      S_DROP: begin
        if (in_meta_wr) begin
          w_drop_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        if (in_sop) begin
          w_drop_nxt    = 1'b1;
          w_sample_elig = 1'b1;
          w_state_nxt   = S_DECIDE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clock) begin
    if (!rx_resetn) begin
      r_elig         <= '0;
      r_rr_ptr       <= '0;
      r_cur_core     <= '0;
      r_data_wr_en   <= '0;
      r_meta_wr_en   <= '0;
      r_data_wr_data <= '0;
      r_meta_wr_data <= '0;
      r_drop         <= 1'b0;
    end else begin
      if (w_sample_elig) r_elig <= w_elig;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_cur_core   <= w_cur_core_nxt;
      r_data_wr_en <= w_data_wr_en_nxt;
      r_meta_wr_en <= w_meta_wr_en_nxt;
      r_drop       <= w_drop_nxt;
      if (in_data_wr) r_data_wr_data <= in_data;
      if (in_meta_wr) r_meta_wr_data <= in_meta;
    end
  end

  assign data_wr_en   = r_data_wr_en;
  assign data_wr_data = r_data_wr_data;
  assign meta_wr_en   = r_meta_wr_en;
  assign meta_wr_data = r_meta_wr_data;
  assign cur_core     = r_cur_core;
  assign drop         = r_drop;

`ifdef PRISM_SP_RX_DISPATCH_STATS_EN
  logic [31:0] r_stat_frames [NRXCORES];
  logic [31:0] r_stat_drops;

  always_ff @(posedge rx_clock) begin
    if (!rx_resetn) begin
      for (int i = 0; i < NRXCORES; i++) r_stat_frames[i] <= '0;
      r_stat_drops <= '0;
    end else begin
      for (int i = 0; i < NRXCORES; i++) begin
        if (r_meta_wr_en[i]) r_stat_frames[i] <= r_stat_frames[i] + 32'd1;
      end
      if (r_drop) r_stat_drops <= r_stat_drops + 32'd1;
    end
  end

  for (genvar g = 0; g < NRXCORES; g++) begin : g_stat_pack
    assign stat_frames[g*32 +: 32] = r_stat_frames[g];
  end
  assign stat_drops = r_stat_drops;
`else
  assign stat_frames = '0;
  assign stat_drops  = '0;
`endif

`ifndef SYNTHESIS
  // Upstream must not write outside a frame that has been decided.
  a_no_wr_outside_frame : assert property (@(posedge rx_clock) disable iff (!rx_resetn)
    ((r_state == S_IDLE) || (r_state == S_DECIDE)) |-> !(in_data_wr || in_meta_wr));
`endif

endmodule

// File: tb/tb_prism_sp_rx_dispatch.sv
// Directed bench for prism_sp_rx_dispatch (NRXCORES=4, 64-bit words,
// 4096-byte data FIFOs). Inputs change 1 ns after the rising edge and the
// registered outputs are inspected at that same point after the next edge.

module tb_prism_sp_rx_dispatch;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int MW = 32;
  localparam int CW = 10;

`ifdef PRISM_SP_RX_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            rx_clock = 1'b0;
  logic            rx_resetn;
  logic            in_sop;
  logic [13:0]     in_len;
  logic            in_data_wr;
  logic [DW-1:0]   in_data;
  logic            in_meta_wr;
  logic [MW-1:0]   in_meta;
  logic [N-1:0]    core_en;
  logic [N*CW-1:0] data_wr_count;
  logic [N-1:0]    meta_full;
  logic [N-1:0]    data_wr_en;
  logic [DW-1:0]   data_wr_data;
  logic [N-1:0]    meta_wr_en;
  logic [MW-1:0]   meta_wr_data;
  logic [1:0]      cur_core;
  logic            drop;
  logic [N*32-1:0] stat_frames;
  logic [31:0]     stat_drops;

  int n_checks = 0;
  int n_errors = 0;
  int seq      = 0;

  prism_sp_rx_dispatch #(
    .NRXCORES(N), .DATA_WIDTH(DW), .META_WIDTH(MW),
    .RX_DATA_FIFO_SIZE(4096), .CNT_WIDTH(CW)
  ) dut (
    .rx_clock(rx_clock), .rx_resetn(rx_resetn),
    .in_sop(in_sop), .in_len(in_len),
    .in_data_wr(in_data_wr), .in_data(in_data),
    .in_meta_wr(in_meta_wr), .in_meta(in_meta),
    .core_en(core_en), .data_wr_count(data_wr_count), .meta_full(meta_full),
    .data_wr_en(data_wr_en), .data_wr_data(data_wr_data),
    .meta_wr_en(meta_wr_en), .meta_wr_data(meta_wr_data),
    .cur_core(cur_core), .drop(drop),
    .stat_frames(stat_frames), .stat_drops(stat_drops)
  );

  always #5 rx_clock = ~rx_clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge rx_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // sop cycle plus the decision cycle; afterwards the DUT is in STEER or DROP.
  task automatic start_frame(input logic [13:0] len);
    in_sop = 1'b1;
    in_len = len;
    tick();
    in_sop = 1'b0;
    tick();
  endtask

  task automatic words(input int n, input logic [N-1:0] exp_en, input string tag);
    logic [DW-1:0] d;
    for (int w = 0; w < n; w++) begin
      seq++;
      d          = 64'hD00D_0000_0000_0000 | 64'(seq);
      in_data_wr = 1'b1;
      in_data    = d;
      tick();
      chk({tag, "_en"}, 128'(data_wr_en), 128'(exp_en));
      if (exp_en != '0) chk({tag, "_data"}, 128'(data_wr_data), 128'(d));
    end
    in_data_wr = 1'b0;
  endtask

  task automatic meta(input logic [N-1:0] exp_en, input logic exp_drop, input string tag);
    logic [MW-1:0] m;
    seq++;
    m          = 32'hE000_0000 | 32'(seq);
    in_meta_wr = 1'b1;
    in_meta    = m;
    tick();
    in_meta_wr = 1'b0;
    chk({tag, "_meta_en"}, 128'(meta_wr_en), 128'(exp_en));
    chk({tag, "_drop"}, 128'(drop), 128'(exp_drop));
    if (exp_en != '0) chk({tag, "_meta_data"}, 128'(meta_wr_data), 128'(m));
  endtask

  initial begin
    rx_resetn     = 1'b0;
    in_sop        = 1'b0;
    in_len        = '0;
    in_data_wr    = 1'b0;
    in_data       = '0;
    in_meta_wr    = 1'b0;
    in_meta       = '0;
    core_en       = 4'b1111;
    data_wr_count = '0;
    meta_full     = '0;
    tick(); tick(); tick();
    chk("rst_data_en", 128'(data_wr_en), 128'(0));
    chk("rst_meta_en", 128'(meta_wr_en), 128'(0));
    chk("rst_drop", 128'(drop), 128'(0));
    chk("rst_cur_core", 128'(cur_core), 128'(0));
    chk("rst_stat_drops", 128'(stat_drops), 128'(0));
    chk("rst_data_word", 128'(data_wr_data), 128'(0));
    rx_resetn = 1'b1;
    tick();

    // Four 64-byte frames, all cores free: plain rotation 0,1,2,3.
    start_frame(14'd64); chk("rr0_core", 128'(cur_core), 128'(0));
    words(8, 4'b0001, "rr0"); meta(4'b0001, 1'b0, "rr0");
    start_frame(14'd64); chk("rr1_core", 128'(cur_core), 128'(1));
    words(8, 4'b0010, "rr1"); meta(4'b0010, 1'b0, "rr1");
    start_frame(14'd64); chk("rr2_core", 128'(cur_core), 128'(2));
    words(8, 4'b0100, "rr2"); meta(4'b0100, 1'b0, "rr2");
    start_frame(14'd64); chk("rr3_core", 128'(cur_core), 128'(3));
    words(8, 4'b1000, "rr3"); meta(4'b1000, 1'b0, "rr3");
    tick();
    chk("stat_frames_rr", stat_frames, STATS ? {4{32'd1}} : 128'(0));

    // Walk rr_ptr to 2, then disable core 2: search from 2 lands on 3, then 0.
    start_frame(14'd16); words(2, 4'b0001, "walk0"); meta(4'b0001, 1'b0, "walk0");
    start_frame(14'd16); words(2, 4'b0010, "walk1"); meta(4'b0010, 1'b0, "walk1");
    core_en = 4'b1011;
    start_frame(14'd16); chk("skip_core", 128'(cur_core), 128'(3));
    words(2, 4'b1000, "skip"); meta(4'b1000, 1'b0, "skip");
    start_frame(14'd16); chk("wrap_core", 128'(cur_core), 128'(0));
    words(1, 4'b0001, "wrap"); meta(4'b0001, 1'b0, "wrap");

    // Only core 1 enabled, 500 words used -> 96 bytes free.
    core_en = 4'b0010;
    data_wr_count[1*CW +: CW] = 10'd500;
    start_frame(14'd100);
    chk("nofit_core_held", 128'(cur_core), 128'(0));
    words(2, 4'b0000, "nofit"); meta(4'b0000, 1'b1, "nofit");
    tick();
    chk("nofit_drop_end", 128'(drop), 128'(0));
    chk("nofit_stat_drops", 128'(stat_drops), STATS ? 128'(1) : 128'(0));
    start_frame(14'd96); chk("exact_fit_core", 128'(cur_core), 128'(1));
    words(2, 4'b0010, "exact"); meta(4'b0010, 1'b0, "exact");
    // 1000 words would be 8000 bytes: free space saturates at 0.
    data_wr_count[1*CW +: CW] = 10'd1000;
    start_frame(14'd64);
    words(1, 4'b0000, "sat"); meta(4'b0000, 1'b1, "sat");

    // rr_ptr is 2 here; core 2 meta FIFO full -> core 3.
    core_en       = 4'b1111;
    data_wr_count = '0;
    meta_full     = 4'b0100;
    start_frame(14'd8); chk("mfull_core", 128'(cur_core), 128'(3));
    words(1, 4'b1000, "mfull");
    meta_full = 4'b0000;
    meta(4'b1000, 1'b0, "mfull");

    // Abandoned frame: 3 words to core 0, then sop without meta.
    start_frame(14'd64); chk("aband_core", 128'(cur_core), 128'(0));
    words(3, 4'b0001, "aband");
    in_sop = 1'b1;
    in_len = 14'd32;
    tick();
    in_sop = 1'b0;
    chk("aband_drop", 128'(drop), 128'(1));
    chk("aband_no_wr", 128'(data_wr_en), 128'(0));
    tick();
    chk("aband_new_core", 128'(cur_core), 128'(1));
    chk("aband_drop_end", 128'(drop), 128'(0));
    words(2, 4'b0010, "newfr");

    // Meta and sop together: meta to core 1, next frame goes to core 2.
    seq++;
    in_meta_wr = 1'b1;
    in_meta    = 32'hE000_0000 | 32'(seq);
    in_sop     = 1'b1;
    in_len     = 14'd16;
    tick();
    in_meta_wr = 1'b0;
    in_sop     = 1'b0;
    chk("b2b_meta_en", 128'(meta_wr_en), 128'(4'b0010));
    chk("b2b_meta_data", 128'(meta_wr_data), 128'(32'hE000_0000 | 32'(seq)));
    chk("b2b_no_drop", 128'(drop), 128'(0));
    tick();
    chk("b2b_new_core", 128'(cur_core), 128'(2));
    words(2, 4'b0100, "b2b"); meta(4'b0100, 1'b0, "b2b");

    // Bring rr_ptr to 2 with cur_core 1, then reset mid-frame.
    start_frame(14'd8); words(1, 4'b1000, "pre3"); meta(4'b1000, 1'b0, "pre3");
    start_frame(14'd8); words(1, 4'b0001, "pre0"); meta(4'b0001, 1'b0, "pre0");
    start_frame(14'd64); chk("prerst_core", 128'(cur_core), 128'(1));
    words(2, 4'b0010, "prerst");
    rx_resetn  = 1'b0;
    in_data_wr = 1'b1;
    in_data    = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    rx_resetn  = 1'b1;
    in_data_wr = 1'b0;
    chk("rst_mid_data_en", 128'(data_wr_en), 128'(0));
    chk("rst_mid_cur_core", 128'(cur_core), 128'(0));
    chk("rst_mid_data_word", 128'(data_wr_data), 128'(0));
    tick();
    chk("rst_after_data_en", 128'(data_wr_en), 128'(0));
    chk("rst_after_meta_en", 128'(meta_wr_en), 128'(0));
    chk("rst_after_stats", 128'(stat_drops), 128'(0));
    start_frame(14'd8); chk("rst_rr_core", 128'(cur_core), 128'(0));
    words(1, 4'b0001, "postrst"); meta(4'b0001, 1'b0, "postrst");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
